p_predict_serial: RTL



---
 rtl/p_predict_serial.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/p_predict_serial.sv
// Serial Kalman covariance prediction P_pred = F*P*F' + Q for a 2x2 state.
// One shared multiplier runs 8 FP products then 8 (FP)F' products in fixed point.
module p_predict_serial #(
  parameter int N    = 16,
  parameter int FRAC = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] F11,
  input  logic signed [N-1:0] F12,
  input  logic signed [N-1:0] F21,
  input  logic signed [N-1:0] F22,
  input  logic signed [N-1:0] P11,
  input  logic signed [N-1:0] P12,
  input  logic signed [N-1:0] P21,
  input  logic signed [N-1:0] P22,
  input  logic signed [N-1:0] Q11,
  input  logic signed [N-1:0] Q12,
  input  logic signed [N-1:0] Q21,
  input  logic signed [N-1:0] Q22,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic signed [N-1:0] Pp11,
  output logic signed [N-1:0] Pp12,
  output logic signed [N-1:0] Pp21,
  output logic signed [N-1:0] Pp22
);

  typedef enum logic [1:0] {IDLE, FP, FPFT, OUT} state_t;

  localparam logic signed [2*N:0] SAT_MAX = {{(N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N:0] SAT_MIN = {{(N+2){1'b1}}, {(N-1){1'b0}}};

  function automatic logic signed [N-1:0] sat_n(input logic signed [2*N:0] v);
    if (v > SAT_MAX) return SAT_MAX[N-1:0];
    if (v < SAT_MIN) return SAT_MIN[N-1:0];
    return v[N-1:0];
  endfunction

  function automatic logic sat_hit(input logic signed [2*N:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  state_t                r_state;
  logic [2:0]            r_k;
  logic signed [2*N:0]   r_acc;
  logic signed [N-1:0]   r_f [4];
  logic signed [N-1:0]   r_p [4];
  logic signed [N-1:0]   r_q [4];
  logic signed [N-1:0]   r_a [4];
  logic signed [N-1:0]   r_r [4];
  logic signed [N-1:0]   r_pp [4];
  logic                  r_sticky;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovf;

  logic [1:0]            w_e;
  logic                  w_t;
  logic signed [N-1:0]   w_opa;
  logic signed [N-1:0]   w_opb;
  logic signed [2*N-1:0] w_prod;
  logic signed [2*N:0]   w_sum;
  logic signed [2*N:0]   w_shift;
  logic signed [N-1:0]   w_sat1;
  logic                  w_clamp1;
  logic signed [N:0]     w_qsum;
  logic signed [2*N:0]   w_qwide;
  logic signed [N-1:0]   w_sat2;
  logic                  w_clamp2;

  assign w_e = r_k[2:1];
  assign w_t = r_k[0];

  // Element e = {row, col}; term t selects the inner-product index.
  always_comb begin
    w_opa = r_f[{w_e[1], w_t}];
    w_opb = r_p[{w_t, w_e[0]}];
    if (r_state == FPFT) begin
      w_opa = r_a[{w_e[1], w_t}];
      w_opb = r_f[{w_e[0], w_t}];
    end
  end

  assign w_prod   = w_opa * w_opb;
  assign w_sum    = r_acc + {w_prod[2*N-1], w_prod};
  assign w_shift  = w_sum >>> FRAC;
  assign w_sat1   = sat_n(w_shift);
  assign w_clamp1 = sat_hit(w_shift);
  assign w_qsum   = {w_sat1[N-1], w_sat1} + {r_q[w_e][N-1], r_q[w_e]};
  assign w_qwide  = {{N{w_qsum[N]}}, w_qsum};
  assign w_sat2   = sat_n(w_qwide);
  assign w_clamp2 = sat_hit(w_qwide);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_k      <= 3'd0;
      r_acc    <= '0;
      r_sticky <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_f[i]  <= '0;
        r_p[i]  <= '0;
        r_q[i]  <= '0;
        r_a[i]  <= '0;
        r_r[i]  <= '0;
        r_pp[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_f[0] <= F11; r_f[1] <= F12; r_f[2] <= F21; r_f[3] <= F22;
            r_p[0] <= P11; r_p[1] <= P12; r_p[2] <= P21; r_p[3] <= P22;
            r_q[0] <= Q11; r_q[1] <= Q12; r_q[2] <= Q21; r_q[3] <= Q22;
            r_sticky <= 1'b0;
            r_k      <= 3'd0;
            r_busy   <= 1'b1;
            r_state  <= FP;
          end
        end
        FP: begin
          if (!w_t) begin
            r_acc <= {w_prod[2*N-1], w_prod};
          end else begin
            r_a[w_e] <= w_sat1;
            if (w_clamp1) r_sticky <= 1'b1;
          end
          r_k <= r_k + 3'd1;
          if (r_k == 3'd7) r_state <= FPFT;
        end
        FPFT: begin
          if (!w_t) begin
            r_acc <= {w_prod[2*N-1], w_prod};
          end else begin
            r_r[w_e] <= w_sat2;
            if (w_clamp1 || w_clamp2) r_sticky <= 1'b1;
          end
          r_k <= r_k + 3'd1;
          if (r_k == 3'd7) r_state <= OUT;
        end
        OUT: begin
          for (int i = 0; i < 4; i++) r_pp[i] <= r_r[i];
          r_done  <= 1'b1;
          r_ovf   <= r_sticky;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;
  assign Pp11 = r_pp[0];
  assign Pp12 = r_pp[1];
  assign Pp21 = r_pp[2];
  assign Pp22 = r_pp[3];

endmodule
